// File: rtl/hpu_acc_pkg.sv
// Shared types, increment encodings and helpers for the bit-bundling accumulator.
package hpu_acc_pkg;

  localparam int MAX_CNT_W = 32;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    BIN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic signed [1:0] SEL_PLUS    = 2'sb01;
  localparam logic signed [1:0] SEL_MINUS   = 2'sb11;
  localparam logic signed [1:0] SEL_ZERO    = 2'sb00;
  localparam logic        [1:0] SEL_ILLEGAL = 2'b10;

  // Widen a 2-bit increment by replicating its sign bit; callers narrow to CNT_W.
  function automatic logic signed [MAX_CNT_W-1:0] sext_inc(input logic signed [1:0] inc);
    return {{(MAX_CNT_W-2){inc[1]}}, inc};
  endfunction

endpackage

// File: rtl/bit_accumulator_lane.sv
// One signed per-lane bundle counter (module acc_lane).
// Saturating arithmetic is selected by the BIT_ACC_SATURATE_EN macro.
module acc_lane
  import hpu_acc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] inc,
  input  logic       en,
  input  logic       clr,
  output logic       sign,
  output logic       illegal,
  output logic       ovf
);

  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] inc_ext;
  logic signed [CNT_W-1:0] cnt_nxt;
`ifdef BIT_ACC_SATURATE_EN
  logic signed [CNT_W:0]   sum;
  logic                    ovf_raw;
`endif

  always_comb begin
    illegal = en && (inc == SEL_ILLEGAL);
    // An illegal code contributes nothing rather than its -2 two's-complement value.
    inc_ext = (inc == SEL_ILLEGAL) ? '0 : CNT_W'(sext_inc(inc));
`ifdef BIT_ACC_SATURATE_EN
    sum     = {cnt[CNT_W-1], cnt} + {inc_ext[CNT_W-1], inc_ext};
    ovf_raw = sum[CNT_W] ^ sum[CNT_W-1];
    if (ovf_raw) begin
      cnt_nxt = sum[CNT_W] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}};
    end else begin
      cnt_nxt = sum[CNT_W-1:0];
    end
    ovf = en && ovf_raw;
`else
    cnt_nxt = cnt + inc_ext;
    ovf     = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_nxt;
    end
  end

  assign sign = cnt[CNT_W-1];

endmodule

// File: rtl/bit_accumulator.sv
// Per-lane bundling accumulator: sums +1/-1/0 increments, binarizes by sign on the last item.
// Optional macro BIT_ACC_SATURATE_EN selects clamping counters with a sticky ovf flag.
module bit_accumulator
  import hpu_acc_pkg::*;
#(
  parameter int LANES = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*LANES-1:0] sel_bits,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [LANES-1:0]   out_bits,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err,
  output logic               ovf
);

  state_t           state;
  state_t           state_nxt;
  logic             acc_en;
  logic             clr;
  logic [LANES-1:0] signs;
  logic [LANES-1:0] lane_ill;
  logic [LANES-1:0] lane_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    acc_lane #(
      .CNT_W(CNT_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (sel_bits[2*i+1:2*i]),
      .en     (acc_en),
      .clr    (clr),
      .sign   (signs[i]),
      .illegal(lane_ill[i]),
      .ovf    (lane_ovf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_en    = 1'b0;
    clr       = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        acc_en   = in_valid;
        if (in_valid && in_last) state_nxt = BIN;
      end
      BIN: begin
        clr       = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // Result register loads on the BIN edge, the same edge that clears the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bits <= '0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (state == BIN) out_bits <= signs;
      err <= err | (|lane_ill);
      ovf <= ovf | (|lane_ovf);
    end
  end

endmodule

// File: tb/tb_bit_accumulator.sv
// Directed self-checking bench for bit_accumulator (LANES=4, CNT_W=4).
module tb_bit_accumulator;
  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] M = 2'b11;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] I = 2'b10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2*LANES-1:0] sel_bits = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [LANES-1:0] out_bits;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             err;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  bit_accumulator #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sel_bits(sel_bits), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_bits(out_bits),
    .out_valid(out_valid), .out_ready(out_ready), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input logic [1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic apply_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] sel, input logic last);
    @(negedge clk);
    sel_bits = sel; in_valid = 1'b1; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; sel_bits = '0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_bits !== 4'b0000) begin errors++; $display("FAIL reset_out_bits got=%b want=0000", out_bits); end
    checks++; if ({err, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {err, ovf}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_majority();
    bit ok;
    send(mk(P, M, Z, Z), 1'b0);
    send(mk(P, M, Z, Z), 1'b0);
    send(mk(M, P, Z, Z), 1'b1);
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL maj_bin_cycle got=%b want=00", {out_valid, in_ready}); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL maj_latency got=%b want=1", out_valid); end
    checks++; if (out_bits !== 4'b0010) begin errors++; $display("FAIL maj_bits got=%b want=0010", out_bits); end
    release_out();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL maj_release got=%b want=01", {out_valid, in_ready}); end
    wait_valid(ok);
    ok = !ok;
  endtask

  task automatic test_tie();
    bit ok;
    send(mk(P, Z, Z, Z), 1'b0);
    send(mk(M, Z, Z, Z), 1'b1);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_timeout got=%b want=1", ok); end
    checks++; if (out_bits !== 4'b0000) begin errors++; $display("FAIL tie_bits got=%b want=0000", out_bits); end
    release_out();
    send(mk(M, Z, Z, Z), 1'b1);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_next_timeout got=%b want=1", ok); end
    checks++; if (out_bits !== 4'b0001) begin errors++; $display("FAIL tie_next_bits got=%b want=0001", out_bits); end
    release_out();
  endtask

  task automatic test_overflow();
    bit ok;
    logic [3:0] exp_bits;
    logic       exp_ovf;
`ifdef BIT_ACC_SATURATE_EN
    exp_bits = 4'b0100; exp_ovf = 1'b1;
`else
    exp_bits = 4'b0000; exp_ovf = 1'b0;
`endif
    apply_reset();
    for (int k = 0; k < 10; k++) send(mk(Z, Z, M, Z), (k == 9));
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got=%b want=1", ok); end
    checks++; if (out_bits !== exp_bits) begin errors++; $display("FAIL ovf_bits got=%b want=%b", out_bits, exp_bits); end
    checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL ovf_flag got=%b want=%b", ovf, exp_ovf); end
    release_out();
  endtask

  task automatic test_backpressure();
    bit ok;
    send(mk(Z, M, Z, Z), 1'b1);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=%b want=1", ok); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k % 2 == 0); in_last = 1'b1; sel_bits = mk(M, M, M, M);
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready, out_bits} !== 6'b10_0010) begin
        errors++; $display("FAIL bp_hold%0d got=%b want=100010", k, {out_valid, in_ready, out_bits});
      end
    end
    in_valid = 1'b0; in_last = 1'b0; sel_bits = '0;
    release_out();
    send(mk(P, Z, Z, Z), 1'b1);
    wait_valid(ok);
    checks++; if (out_bits !== 4'b0000) begin errors++; $display("FAIL bp_next_bits got=%b want=0000", out_bits); end
    release_out();
  endtask

  task automatic test_illegal();
    bit ok;
    apply_reset();
    send(mk(M, Z, Z, I), 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err got=%b want=1", err); end
    send(mk(M, Z, Z, Z), 1'b1);
    wait_valid(ok);
    checks++; if (out_bits !== 4'b0001) begin errors++; $display("FAIL ill_bits got=%b want=0001", out_bits); end
    release_out();
    send(mk(P, P, P, P), 1'b1);
    wait_valid(ok);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_sticky got=%b want=1", err); end
    release_out();
  endtask

  task automatic test_reset_mid();
    bit ok;
    send(mk(P, P, P, P), 1'b0);
    send(mk(P, P, P, P), 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if ({in_ready, out_valid, out_bits, err, ovf} !== 8'b1000_0000) begin
      errors++; $display("FAIL mid_reset got=%b want=10000000", {in_ready, out_valid, out_bits, err, ovf});
    end
    @(negedge clk); rst_n = 1'b1;
    send(mk(M, M, M, M), 1'b1);
    wait_valid(ok);
    checks++; if (out_bits !== 4'b1111) begin errors++; $display("FAIL mid_bits got=%b want=1111", out_bits); end
    release_out();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); out_ready = 1'b1;
    send(mk(Z, M, Z, Z), 1'b1);
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL b2b_bin got=%b want=00", {out_valid, in_ready}); end
    @(posedge clk); #1;
    checks++; if ({out_valid, out_bits} !== 5'b1_0010) begin errors++; $display("FAIL b2b_hold got=%b want=10010", {out_valid, out_bits}); end
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_acc got=%b want=01", {out_valid, in_ready}); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_majority();
    test_tie();
    test_overflow();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
